// File: rtl/formula_res_buffer_if.sv
// Handshake bundle for formula_res_buffer: pipeline launch/result side and
// ready/valid consumer side, plus occupancy and error status.
interface formula_res_buffer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  logic                         arg_vld;
  logic                         arg_rdy;
  logic                         res_vld;
  logic [WIDTH-1:0]             res;
  logic                         out_vld;
  logic [WIDTH-1:0]             out_data;
  logic                         out_rdy;
  logic [$clog2(DEPTH+1)-1:0]   fill;
  logic                         err;

  modport slave (
    input  arg_vld, res_vld, res, out_rdy,
    output arg_rdy, out_vld, out_data, fill, err
  );

  modport master (
    output arg_vld, res_vld, res, out_rdy,
    input  arg_rdy, out_vld, out_data, fill, err
  );
endinterface

// File: rtl/formula_res_buffer.sv
// Credit-managed result FIFO behind a fixed-latency, non-stallable pipeline.
// Credit covers results already stored plus results still in flight.
module formula_res_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  formula_res_buffer_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    inflight_q;
  logic             err_q;

  logic [FW:0]      owed;
  logic             credit;
  logic             full;
  logic             pop;
  logic             launch;
  logic             retire;
  logic             push;
  logic             bad_launch;
  logic             bad_result;

  // Credit depends on registers only, so arg_rdy has no input-to-output path.
  always_comb begin
    owed       = {1'b0, fill_q} + {1'b0, inflight_q};
    credit     = owed < (FW + 1)'(DEPTH);
    full       = fill_q == FW'(DEPTH);
    pop        = (fill_q != '0) & bus.out_rdy;
    launch     = bus.arg_vld & credit;
    retire     = bus.res_vld & (inflight_q != '0);
    push       = retire & (~full | pop);
    bad_launch = bus.arg_vld & ~credit;
    bad_result = bus.res_vld & ((inflight_q == '0) | (full & ~pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase

      case ({launch, retire})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase

      if (bad_launch | bad_result) err_q <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.res;
  end

  assign bus.arg_rdy  = credit;
  assign bus.out_vld  = fill_q != '0;
  assign bus.out_data = mem[rd_ptr];
  assign bus.fill     = fill_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_formula_res_buffer.sv
// Self-checking bench for formula_res_buffer: directed vector table, hand
// sequences for reset/error/stream cases, and a queue-based reference model.
module tb_formula_res_buffer;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  formula_res_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  formula_res_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          av;
    bit          rv;
    logic [15:0] r;
    bit          ordy;
    bit          e_vld;
    logic [15:0] e_data;
    logic [2:0]  e_fill;
    bit          e_rdy;
    bit          e_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: results owed, stored results in order, sticky error.
  int          m_infl;
  logic [15:0] m_q[$];
  bit          m_err;
  logic [15:0] popped[$];

  function automatic vec_t mk(bit av, bit rv, logic [15:0] r, bit ordy,
                              bit ev, logic [15:0] ed, int ef, bit er, bit ee);
    vec_t v;
    v.av = av; v.rv = rv; v.r = r; v.ordy = ordy;
    v.e_vld = ev; v.e_data = ed; v.e_fill = 3'(ef); v.e_rdy = er; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_infl = 0;
    m_q.delete();
    m_err = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_out_vld"}, 32'(bus.out_vld), 32'(m_q.size() != 0));
    chk({tag, "_fill"},    32'(bus.fill),    32'(m_q.size()));
    chk({tag, "_arg_rdy"}, 32'(bus.arg_rdy), 32'((m_q.size() + m_infl) < DEPTH));
    chk({tag, "_err"},     32'(bus.err),     32'(m_err));
    if (m_q.size() != 0) chk({tag, "_out_data"}, 32'(bus.out_data), 32'(m_q[0]));
  endtask

  // One clock with the reference model advanced by the spec rules.
  task automatic cycle(input bit av, input bit rv, input logic [15:0] r,
                       input bit ordy, input string tag);
    bit rdy;
    bit pop;
    bus.arg_vld = av;
    bus.res_vld = rv;
    bus.res     = r;
    bus.out_rdy = ordy;
    if (ordy && bus.out_vld) popped.push_back(bus.out_data);
    rdy = (m_q.size() + m_infl) < DEPTH;
    pop = (m_q.size() != 0) && ordy;
    if (av && !rdy) m_err = 1;
    if (pop) void'(m_q.pop_front());
    if (rv) begin
      if (m_infl == 0) m_err = 1;
      else begin
        m_infl--;
        if (m_q.size() == DEPTH) m_err = 1;
        else m_q.push_back(r);
      end
    end
    if (av && rdy) m_infl++;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    bus.arg_vld = 0;
    bus.res_vld = 0;
    bus.res     = '0;
    bus.out_rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 0;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_sent;
    bit pv[2];
    logic [15:0] pd[2];
    bit av;
    bit rv;
    logic [15:0] r;

    rst_n = 0;
    idle_inputs();
    model_reset();
    #2;
    chk("reset_out_vld", 32'(bus.out_vld), 32'd0);
    chk("reset_fill",    32'(bus.fill),    32'd0);
    chk("reset_err",     32'(bus.err),     32'd0);
    chk("reset_arg_rdy", 32'(bus.arg_rdy), 32'd1);
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;

    // Single item, then credit exhaustion / return and an illegal launch.
    tbl.push_back(mk(1,0,16'h00,0, 0,16'h00,0,1,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,16'h00,0, 0,16'h00,0,1,0));
    tbl.push_back(mk(0,1,16'h15,0, 1,16'h15,1,1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,16'h00,0, 1,16'h15,1,1,0));
    tbl.push_back(mk(0,0,16'h00,1, 0,16'h00,0,1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,16'h00,0, 0,16'h00,0,1,0));
    tbl.push_back(mk(1,0,16'h00,0, 0,16'h00,0,0,0));
    tbl.push_back(mk(0,1,16'hA0,0, 1,16'hA0,1,0,0));
    tbl.push_back(mk(0,1,16'hA1,0, 1,16'hA0,2,0,0));
    tbl.push_back(mk(0,1,16'hA2,0, 1,16'hA0,3,0,0));
    tbl.push_back(mk(0,1,16'hA3,0, 1,16'hA0,4,0,0));
    tbl.push_back(mk(0,0,16'h00,1, 1,16'hA1,3,1,0));
    tbl.push_back(mk(1,0,16'h00,0, 1,16'hA1,3,0,0));
    tbl.push_back(mk(0,1,16'hA4,1, 1,16'hA2,3,1,0));
    tbl.push_back(mk(1,0,16'h00,0, 1,16'hA2,3,0,0));
    tbl.push_back(mk(1,0,16'h00,0, 1,16'hA2,3,0,1));
    tbl.push_back(mk(0,1,16'hA5,0, 1,16'hA2,4,0,1));
    tbl.push_back(mk(0,0,16'h00,1, 1,16'hA3,3,1,1));

    foreach (tbl[i]) begin
      bus.arg_vld = tbl[i].av;
      bus.res_vld = tbl[i].rv;
      bus.res     = tbl[i].r;
      bus.out_rdy = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_vld", i), 32'(bus.out_vld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_fill", i),    32'(bus.fill),    32'(tbl[i].e_fill));
      chk($sformatf("tbl%0d_arg_rdy", i), 32'(bus.arg_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_err", i),     32'(bus.err),     32'(tbl[i].e_err));
      if (tbl[i].e_vld)
        chk($sformatf("tbl%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
    end

    // Full-rate stream through a 2-cycle pipeline with the consumer always ready.
    do_reset();
    popped.delete();
    pv[0] = 0; pv[1] = 0;
    pd[0] = '0; pd[1] = '0;
    n_sent = 0;
    for (int c = 0; c < 30; c++) begin
      av = n_sent < 20;
      if (av) chk("stream_arg_rdy", 32'(bus.arg_rdy), 32'd1);
      rv = pv[1];
      r  = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = av;    pd[0] = 16'(n_sent + 1);
      if (av) n_sent++;
      cycle(av, rv, r, 1, "stream");
    end
    chk("stream_count", 32'(popped.size()), 32'd20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      chk($sformatf("stream_order%0d", i), 32'(popped[i]), 32'(i + 1));
    chk("stream_err", 32'(bus.err), 32'd0);

    // Legal random traffic, then unconstrained traffic including protocol errors.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      av = ($urandom_range(1, 0) == 1) && ((m_q.size() + m_infl) < DEPTH);
      rv = ($urandom_range(2, 0) == 0) && (m_infl > 0);
      cycle(av, rv, 16'($urandom), $urandom_range(3, 0) != 0, "rand_legal");
    end
    for (int c = 0; c < 100; c++)
      cycle($urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0, 16'($urandom),
            $urandom_range(1, 0) == 1, "rand_any");

    // Reset asserted between clock edges with results stored and in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, '0, 0, "mid_fill");
    cycle(0, 1, 16'h11, 0, "mid_fill");
    cycle(0, 1, 16'h22, 0, "mid_fill");
    #3 rst_n = 0;
    #1;
    chk("async_out_vld", 32'(bus.out_vld), 32'd0);
    chk("async_fill",    32'(bus.fill),    32'd0);
    chk("async_arg_rdy", 32'(bus.arg_rdy), 32'd1);
    chk("async_err",     32'(bus.err),     32'd0);
    idle_inputs();
    model_reset();
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    check_model("post_release");

    // Result with nothing owed is dropped and flags an error.
    cycle(0, 1, 16'h5A, 0, "orphan_res");
    chk("orphan_err",  32'(bus.err),  32'd1);
    chk("orphan_fill", 32'(bus.fill), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
